// File: rtl/axi_audio_cfg_sequencer.sv
// AXI4-Lite master sequencer: one command -> one AXI write, read, or write+read-verify, then one response pulse.
// Zero-wait slave: response 3 cycles after acceptance (5 for verify). cmd_ready low while busy; responses not backpressured.
module axi_audio_cfg_sequencer #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [1:0]                        cmd_op,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_offset,
  input  logic [31:0]                       cmd_wdata,
  output logic                              rsp_valid,
  output logic [31:0]                       rsp_rdata,
  output logic [2:0]                        rsp_status,
  output logic                              busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

  localparam logic [1:0] OP_WR = 2'b00;
  localparam logic [1:0] OP_RD = 2'b01;
  localparam logic [1:0] OP_WV = 2'b10;

  localparam logic [2:0] ST_OK       = 3'd0;
  localparam logic [2:0] ST_SLVERR   = 3'd1;
  localparam logic [2:0] ST_MISMATCH = 3'd2;
  localparam logic [2:0] ST_ILLEGAL  = 3'd4;

  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP} state_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] wdata;
  } cmd_t;

  state_t        state;
  cmd_t          cmd_q;
  logic [AW-1:0] cmd_addr;

  assign cmd_addr     = BASE_ADDR + (cmd_offset & WORD_MASK);
  assign M_AXI_WDATA  = cmd_q.wdata;
  assign M_AXI_WSTRB  = '1;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state         <= IDLE;
      cmd_q         <= '0;
      cmd_ready     <= 1'b0;
      busy          <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_status    <= '0;
      M_AXI_AWADDR  <= '0;
      M_AXI_ARADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready    <= 1'b0;
            busy         <= 1'b1;
            cmd_q        <= '{op: cmd_op, wdata: cmd_wdata};
            M_AXI_AWADDR <= cmd_addr;
            M_AXI_ARADDR <= cmd_addr;
            rsp_rdata    <= '0;
            rsp_status   <= ST_OK;
            case (cmd_op)
              OP_WR, OP_WV: begin
                state         <= WR_AW_W;
                M_AXI_AWVALID <= 1'b1;
                M_AXI_WVALID  <= 1'b1;
              end
              OP_RD: begin
                state         <= RD_AR;
                M_AXI_ARVALID <= 1'b1;
              end
              default: begin
                state      <= RESP;
                rsp_valid  <= 1'b1;
                rsp_status <= ST_ILLEGAL;
              end
            endcase
          end
        end

        WR_AW_W: begin
          // AW and W complete independently; leave once neither is still pending.
          if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
          if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
            state        <= WR_B;
            M_AXI_BREADY <= 1'b1;
          end
        end

        WR_B: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            if (M_AXI_BRESP != 2'b00) begin
              state      <= RESP;
              rsp_valid  <= 1'b1;
              rsp_status <= ST_SLVERR;
            end else if (cmd_q.op == OP_WV) begin
              state         <= RD_AR;
              M_AXI_ARVALID <= 1'b1;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end
          end
        end

        RD_AR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= RD_R;
          end
        end

        RD_R: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            rsp_rdata    <= M_AXI_RDATA;
            rsp_valid    <= 1'b1;
            state        <= RESP;
            if (M_AXI_RRESP != 2'b00)
              rsp_status <= ST_SLVERR;
            else if (cmd_q.op == OP_WV && M_AXI_RDATA != cmd_q.wdata)
              rsp_status <= ST_MISMATCH;
            else
              rsp_status <= ST_OK;
          end
        end

        RESP: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_audio_cfg_sequencer.sv
// Directed bench for axi_audio_cfg_sequencer with a configurable AXI4-Lite slave model and a response scoreboard.
module tb_axi_audio_cfg_sequencer;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [1:0] OP_WR = 2'b00, OP_RD = 2'b01, OP_WV = 2'b10, OP_RSV = 2'b11;

  logic        tb_ACLK = 1'b0;
  logic        tb_ARESET;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_offset, cmd_wdata;
  logic        rsp_valid, busy;
  logic [31:0] rsp_rdata;
  logic [2:0]  rsp_status;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  axi_audio_cfg_sequencer #(.BASE_ADDR(BASE)) dut (
    .ACLK(tb_ACLK), .ARESET(tb_ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_offset(cmd_offset), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status), .busy(busy),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 tb_ACLK = ~tb_ACLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge tb_ACLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int          aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_xor = 32'h0;
  int          aw_wait, w_wait, b_cnt;
  logic        aw_got, w_got, b_act, r_act;
  logic [31:0] aw_addr_q, w_data_q, r_data_q, last_awaddr, last_araddr;
  logic [3:0]  w_strb_q, last_wstrb;
  int          aw_hs, ar_hs;
  logic [31:0] mem [16];
  logic        aw_fire, w_fire, ar_fire, wr_fire;
  logic [31:0] wr_addr, wr_data;

  assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_wait >= aw_delay);
  assign M_AXI_WREADY  = M_AXI_WVALID && (w_wait >= w_delay);
  assign M_AXI_BVALID  = b_act && (b_cnt == 0);
  assign M_AXI_BRESP   = bresp_cfg;
  assign M_AXI_ARREADY = M_AXI_ARVALID;
  assign M_AXI_RVALID  = r_act;
  assign M_AXI_RDATA   = r_data_q;
  assign M_AXI_RRESP   = rresp_cfg;
  assign aw_fire = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_fire  = M_AXI_WVALID && M_AXI_WREADY;
  assign ar_fire = M_AXI_ARVALID && M_AXI_ARREADY;
  assign wr_fire = (aw_got || aw_fire) && (w_got || w_fire);
  assign wr_addr = aw_fire ? M_AXI_AWADDR : aw_addr_q;
  assign wr_data = w_fire ? M_AXI_WDATA : w_data_q;

  always @(posedge tb_ACLK or posedge tb_ARESET) begin
    if (tb_ARESET) begin
      aw_wait <= 0; w_wait <= 0; b_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_act <= 1'b0; r_act <= 1'b0;
      aw_addr_q <= '0; w_data_q <= '0; w_strb_q <= '0; r_data_q <= '0;
    end else begin
      if (M_AXI_AWVALID && !M_AXI_AWREADY) aw_wait <= aw_wait + 1;
      if (M_AXI_WVALID && !M_AXI_WREADY)   w_wait  <= w_wait + 1;
      if (aw_fire) begin
        aw_got <= 1'b1; aw_addr_q <= M_AXI_AWADDR; aw_wait <= 0; aw_hs <= aw_hs + 1;
      end
      if (w_fire) begin
        w_got <= 1'b1; w_data_q <= M_AXI_WDATA; w_strb_q <= M_AXI_WSTRB; w_wait <= 0;
      end
      if (wr_fire) begin
        aw_got <= 1'b0; w_got <= 1'b0; b_act <= 1'b1; b_cnt <= b_delay;
        last_awaddr <= wr_addr;
        last_wstrb  <= w_fire ? M_AXI_WSTRB : w_strb_q;
      end
      if (b_act && b_cnt != 0) b_cnt <= b_cnt - 1;
      if (M_AXI_BVALID && M_AXI_BREADY) b_act <= 1'b0;
      if (ar_fire) begin
        r_act <= 1'b1; r_data_q <= mem[M_AXI_ARADDR[5:2]] ^ rdata_xor;
        last_araddr <= M_AXI_ARADDR; ar_hs <= ar_hs + 1;
      end
      if (M_AXI_RVALID && M_AXI_RREADY) r_act <= 1'b0;
    end
  end

  always @(posedge tb_ACLK)
    if (!tb_ARESET && wr_fire && bresp_cfg == 2'b00) mem[wr_addr[5:2]] <= wr_data;

  initial begin
    aw_hs = 0; ar_hs = 0; last_awaddr = '0; last_araddr = '0; last_wstrb = '0;
  end

  // ---------------- monitors ----------------
  int proto_viol = 0, valid_cycles = 0, rsp_count = 0, rsp_edge = 0;
  logic p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;
  logic [31:0] p_awaddr, p_wdata, p_araddr;

  // A VALID seen without READY must still be high, with unchanged payload, one cycle later.
  always @(negedge tb_ACLK) begin
    if (tb_ARESET) begin
      p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0;
    end else begin
      if ((p_aw && (!M_AXI_AWVALID || M_AXI_AWADDR !== p_awaddr)) ||
          (p_w  && (!M_AXI_WVALID  || M_AXI_WDATA  !== p_wdata))  ||
          (p_ar && (!M_AXI_ARVALID || M_AXI_ARADDR !== p_araddr)) ||
          ((M_AXI_AWVALID || M_AXI_WVALID) && M_AXI_ARVALID))
        proto_viol <= proto_viol + 1;
      p_aw <= M_AXI_AWVALID && !M_AXI_AWREADY; p_awaddr <= M_AXI_AWADDR;
      p_w  <= M_AXI_WVALID && !M_AXI_WREADY;   p_wdata  <= M_AXI_WDATA;
      p_ar <= M_AXI_ARVALID && !M_AXI_ARREADY; p_araddr <= M_AXI_ARADDR;
    end
    if (M_AXI_AWVALID || M_AXI_WVALID || M_AXI_ARVALID) valid_cycles <= valid_cycles + 1;
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic [2:0]  status;
  } exp_t;
  exp_t sb[$];

  always @(negedge tb_ACLK) begin
    if (rsp_valid) begin
      exp_t e;
      rsp_edge = cyc + 1;
      rsp_count++;
      if (sb.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_status", 32'(rsp_status), 32'(e.status));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [1:0] op, input logic [31:0] off, input logic [31:0] wdata,
                      input bit expect_rsp, input logic [31:0] exp_rdata,
                      input logic [2:0] exp_status, output int acc);
    if (expect_rsp) sb.push_back('{exp_rdata, exp_status});
    @(negedge tb_ACLK);
    cmd_valid = 1'b1; cmd_op = op; cmd_offset = off; cmd_wdata = wdata;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        acc = cyc + 1;
        @(posedge tb_ACLK);
        #1 cmd_valid = 1'b0;
        break;
      end
      @(negedge tb_ACLK);
    end
    cmd_valid = 1'b0;
    if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge tb_ACLK);
      #1;
      n++;
    end
    chk("rsp_pending", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] wr_tab [4] = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};
  int acc, aw0, ar0, vc0, rc0;

  initial begin
    tb_ARESET = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_offset = '0; cmd_wdata = '0;
    repeat (2) @(negedge tb_ACLK);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy_rsp", 32'({busy, rsp_valid}), 32'd0);
    chk("rst_handshakes", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_status", 32'(rsp_status), 32'd0);
    chk("rst_addr_data", M_AXI_AWADDR | M_AXI_ARADDR | M_AXI_WDATA, 32'd0);
    tb_ARESET = 1'b0;
    @(negedge tb_ACLK);
    chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 4; i++) begin
      send(OP_WR, 32'(i * 4), wr_tab[i], 1'b1, 32'h0, 3'd0, acc);
      if (i == 0) begin
        @(negedge tb_ACLK);
        chk("wr_valids_t1", 32'({M_AXI_AWVALID, M_AXI_WVALID}), 32'b11);
        chk("wr_ready_busy_t1", 32'({cmd_ready, busy}), 32'b01);
      end
      wait_rsp();
      if (i == 0) begin
        chk("wr_latency", 32'(rsp_edge - acc), 32'd3);
        @(negedge tb_ACLK);
        chk("rsp_pulse_ready_back", 32'({rsp_valid, cmd_ready, busy}), 32'b010);
      end
      chk("wr_awaddr", last_awaddr, BASE + 32'(i * 4));
      chk("wr_wstrb", 32'(last_wstrb), 32'hF);
      send(OP_RD, 32'(i * 4), 32'h0, 1'b1, wr_tab[i], 3'd0, acc);
      wait_rsp();
      if (i == 0) chk("rd_latency", 32'(rsp_edge - acc), 32'd3);
      chk("rd_araddr", last_araddr, BASE + 32'(i * 4));
    end

    rdata_xor = 32'h8; aw0 = aw_hs; ar0 = ar_hs;
    send(OP_WV, 32'h4, 32'h12345678, 1'b1, 32'h12345670, 3'd2, acc);
    wait_rsp();
    chk("wv_mismatch_aw_count", 32'(aw_hs - aw0), 32'd1);
    chk("wv_mismatch_ar_count", 32'(ar_hs - ar0), 32'd1);
    chk("wv_latency", 32'(rsp_edge - acc), 32'd5);
    rdata_xor = 32'h0;
    send(OP_WV, 32'hC, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 3'd0, acc);
    wait_rsp();

    bresp_cfg = 2'b10; ar0 = ar_hs;
    send(OP_WV, 32'h0, 32'h11112222, 1'b1, 32'h0, 3'd1, acc);
    wait_rsp();
    chk("slverr_no_ar", 32'(ar_hs - ar0), 32'd0);
    bresp_cfg = 2'b00; rresp_cfg = 2'b11;
    send(OP_RD, 32'h0, 32'h0, 1'b1, 32'h0101FFFF, 3'd1, acc);
    wait_rsp();
    rresp_cfg = 2'b00;

    aw_delay = 0; w_delay = 3;
    send(OP_WR, 32'h8, 32'hA5A50001, 1'b1, 32'h0, 3'd0, acc);
    repeat (2) @(negedge tb_ACLK);
    chk("skew_aw_first", 32'({M_AXI_AWVALID, M_AXI_WVALID}), 32'b01);
    wait_rsp();
    chk("skew_aw_first_latency", 32'(rsp_edge - acc), 32'd6);
    aw_delay = 3; w_delay = 0;
    send(OP_WR, 32'hC, 32'hA5A50002, 1'b1, 32'h0, 3'd0, acc);
    repeat (2) @(negedge tb_ACLK);
    chk("skew_w_first", 32'({M_AXI_AWVALID, M_AXI_WVALID}), 32'b10);
    wait_rsp();
    chk("skew_w_first_latency", 32'(rsp_edge - acc), 32'd6);
    aw_delay = 2; w_delay = 2; b_delay = 1;
    send(OP_WR, 32'h0, 32'hA5A50003, 1'b1, 32'h0, 3'd0, acc);
    repeat (4) @(negedge tb_ACLK);
    chk("b_wait_bready_held", 32'({M_AXI_BREADY, M_AXI_BVALID}), 32'b10);
    wait_rsp();
    chk("skew_same_bwait_latency", 32'(rsp_edge - acc), 32'd6);
    aw_delay = 0; w_delay = 0; b_delay = 0;
    send(OP_RD, 32'h8, 32'h0, 1'b1, 32'hA5A50001, 3'd0, acc); wait_rsp();
    send(OP_RD, 32'hC, 32'h0, 1'b1, 32'hA5A50002, 3'd0, acc); wait_rsp();
    send(OP_RD, 32'h0, 32'h0, 1'b1, 32'hA5A50003, 3'd0, acc); wait_rsp();

    vc0 = valid_cycles;
    send(OP_RSV, 32'h4, 32'hFFFF, 1'b1, 32'h0, 3'd4, acc);
    wait_rsp();
    chk("rsv_latency", 32'(rsp_edge - acc), 32'd1);
    chk("rsv_no_axi_valid", 32'(valid_cycles - vc0), 32'd0);

    send(OP_WR, 32'h7, 32'h77770007, 1'b1, 32'h0, 3'd0, acc);
    wait_rsp();
    chk("offset7_awaddr", last_awaddr, BASE + 32'h4);
    send(OP_RD, 32'h4, 32'h0, 1'b1, 32'h77770007, 3'd0, acc);
    wait_rsp();

    aw_delay = 100;
    send(OP_WR, 32'h8, 32'hDEADBEEF, 1'b0, 32'h0, 3'd0, acc);
    repeat (3) @(negedge tb_ACLK);
    chk("aw_stalled", 32'(M_AXI_AWVALID), 32'd1);
    rc0 = rsp_count;
    #2 tb_ARESET = 1'b1;
    #1;
    chk("async_rst_valids", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}), 32'd0);
    chk("async_rst_busy_ready", 32'({busy, cmd_ready}), 32'd0);
    repeat (2) @(negedge tb_ACLK);
    tb_ARESET = 1'b0; aw_delay = 0;
    @(negedge tb_ACLK);
    chk("cmd_ready_after_midrst", 32'(cmd_ready), 32'd1);
    repeat (2) @(negedge tb_ACLK);
    chk("midrst_no_rsp", 32'(rsp_count - rc0), 32'd0);
    send(OP_WR, 32'h8, 32'h0BADF00D, 1'b1, 32'h0, 3'd0, acc);
    wait_rsp();
    send(OP_RD, 32'h8, 32'h0, 1'b1, 32'h0BADF00D, 3'd0, acc);
    wait_rsp();

    chk("protocol_violations", 32'(proto_viol), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
